// File: rtl/calc_display.sv
// calc_display: multiplexed 4-digit hex display and status LEDs for the stack calculator.
// A debounced page button selects which 16-bit half of the 32-bit result is shown.
module calc_display #(
  parameter int DIGIT_PERIOD    = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        error_bit,
  input  logic        empty_stack,
  input  logic [9:0]  stack_size,
  input  logic        page_btn,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [7:0]  led
);

  localparam int SCAN_W = $clog2(DIGIT_PERIOD);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIGIT_PERIOD - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  logic [SCAN_W-1:0] scan_cnt_r;
  logic [1:0]        idx_r;
  logic              sync1_r;
  logic              sync2_r;
  logic              db_level_r;
  logic [DEB_W-1:0]  db_cnt_r;
  logic              page_r;

  logic [3:0]        nibble_s;
  logic [6:0]        seg_s;
  logic              dp_s;
  logic [3:0]        an_s;
  logic [7:0]        led_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'b1000000;
      4'h1: code = 7'b1111001;
      4'h2: code = 7'b0100100;
      4'h3: code = 7'b0110000;
      4'h4: code = 7'b0011001;
      4'h5: code = 7'b0010010;
      4'h6: code = 7'b0000010;
      4'h7: code = 7'b1111000;
      4'h8: code = 7'b0000000;
      4'h9: code = 7'b0010000;
      4'hA: code = 7'b0001000;
      4'hB: code = 7'b0000011;
      4'hC: code = 7'b1000110;
      4'hD: code = 7'b0100001;
      4'hE: code = 7'b0000110;
      4'hF: code = 7'b0001110;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Scan timer: dwell DIGIT_PERIOD cycles on each digit, then advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_r <= '0;
      idx_r      <= 2'd0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= '0;
      idx_r      <= idx_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
    end
  end

  // Button synchroniser and debouncer; each debounced press flips the page.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      db_level_r <= 1'b0;
      db_cnt_r   <= '0;
      page_r     <= 1'b0;
    end else begin
      sync1_r <= page_btn;
      sync2_r <= sync1_r;
      if (sync2_r == db_level_r) begin
        db_cnt_r <= '0;
      end else if (db_cnt_r == DEB_LAST) begin
        db_level_r <= sync2_r;
        db_cnt_r   <= '0;
        if (sync2_r) begin
          page_r <= ~page_r;
        end else begin
          page_r <= page_r;
        end
      end else begin
        db_cnt_r <= db_cnt_r + DEB_W'(1);
      end
    end
  end

  // Digit content for the current scan position; error beats empty beats the number.
  always_comb begin
    nibble_s = value[{page_r, idx_r, 2'b00} +: 4];
    seg_s    = SEG_BLANK;
    dp_s     = 1'b1;
    an_s     = 4'b1111;
    led_s    = {error_bit, (stack_size >= 10'd127) ? 7'h7F : stack_size[6:0]};

    case (idx_r)
      2'd0:    an_s = 4'b1110;
      2'd1:    an_s = 4'b1101;
      2'd2:    an_s = 4'b1011;
      2'd3:    an_s = 4'b0111;
      default: an_s = 4'b1111;
    endcase

    if (error_bit) begin
      case (idx_r)
        2'd3:    seg_s = SEG_E;
        2'd2:    seg_s = SEG_R;
        2'd1:    seg_s = SEG_R;
        default: seg_s = SEG_BLANK;
      endcase
    end else if (empty_stack) begin
      seg_s = SEG_DASH;
    end else begin
      seg_s = hex_to_seg(nibble_s);
    end

    // The decimal point on the rightmost digit marks the high half.
    if ((idx_r == 2'd0) && page_r && !error_bit && !empty_stack) begin
      dp_s = 1'b0;
    end else begin
      dp_s = 1'b1;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
      led <= 8'h00;
    end else begin
      seg <= seg_s;
      dp  <= dp_s;
      an  <= an_s;
      led <= led_s;
    end
  end

endmodule

// File: tb/tb_calc_display.sv
// Scoreboard bench for calc_display: a cycle-level reference model predicts every output
// word; a separate monitor pops and compares one prediction per clock edge.
module tb_calc_display;

  localparam int DP  = 4;
  localparam int DEB = 3;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] E_SEG     = 7'b0000110;
  localparam logic [6:0] R_SEG     = 7'b0101111;
  localparam logic [6:0] DASH_SEG  = 7'b0111111;
  localparam logic [6:0] BLANK_SEG = 7'b1111111;

  logic        clk;
  logic        reset;
  logic [31:0] value;
  logic        error_bit;
  logic        empty_stack;
  logic [9:0]  stack_size;
  logic        page_btn;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  logic [19:0] exp_q[$];
  int          cyc_q[$];

  // reference model state
  int m_n;
  int m_run;
  bit m_page;
  bit m_level;
  bit m_b1;
  bit m_b2;

  logic [19:0] mon_e;
  int          mon_c;

  calc_display #(.DIGIT_PERIOD(DP), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .value(value), .error_bit(error_bit),
    .empty_stack(empty_stack), .stack_size(stack_size), .page_btn(page_btn),
    .seg(seg), .dp(dp), .an(an), .led(led));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Predict the outputs produced by the coming clock edge from the current inputs.
  task automatic predict();
    logic [6:0] s;
    logic       d;
    logic [3:0] a;
    logic [7:0] l;
    int         idx;
    int         nib;
    int         sat;
    bit         synced;
    if (reset) begin
      s = 7'h7F; d = 1'b1; a = 4'hF; l = 8'h00;
      m_n = 0; m_run = 0; m_page = 1'b0; m_level = 1'b0; m_b1 = 1'b0; m_b2 = 1'b0;
    end else begin
      idx = (m_n / DP) % 4;
      nib = int'((value >> (16 * int'(m_page) + 4 * idx)) & 32'hF);
      if (error_bit)        s = (idx == 3) ? E_SEG : ((idx == 0) ? BLANK_SEG : R_SEG);
      else if (empty_stack) s = DASH_SEG;
      else                  s = HEX_SEG[nib];
      a = 4'hF;
      a[idx] = 1'b0;
      d = !(idx == 0 && m_page && !error_bit && !empty_stack);
      sat = (int'(stack_size) > 127) ? 127 : int'(stack_size);
      l = {error_bit, sat[6:0]};
      // advance time, then debounce on the button level seen two edges ago
      m_n++;
      synced = m_b2;
      if (synced != m_level) m_run++;
      else m_run = 0;
      if (m_run == DEB) begin
        m_level = synced;
        m_run = 0;
        if (synced) m_page = ~m_page;
      end
      m_b2 = m_b1;
      m_b1 = page_btn;
    end
    exp_q.push_back({s, d, a, l});
    cyc_q.push_back(cycle_no);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      predict();
      @(negedge clk);
      cycle_no++;
    end
  endtask

  // Monitor: one DUT output word per clock edge, compared against the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        checks++;
        if ({seg, dp, an, led} !== mon_e) begin
          errors++;
          $display("FAIL out cyc %0d got seg=%b dp=%b an=%b led=%h exp seg=%b dp=%b an=%b led=%h",
                   mon_c, seg, dp, an, led, mon_e[19:13], mon_e[12], mon_e[11:8], mon_e[7:0]);
        end
      end
    end
  end

  int btn_left;

  initial begin
    reset = 1'b1; value = 32'h0; error_bit = 1'b0; empty_stack = 1'b0;
    stack_size = 10'd0; page_btn = 1'b0;
    @(negedge clk);

    // reset, then scan the low half of a known value
    tick(3);
    reset = 1'b0; value = 32'h1234ABCD;
    tick(20);

    // two debounced presses: to page 1 and back
    page_btn = 1'b1; tick(8);
    page_btn = 1'b0; tick(20);
    page_btn = 1'b1; tick(8);
    page_btn = 1'b0; tick(20);

    // short glitches must not flip the page
    for (int i = 0; i < 5; i++) begin
      page_btn = 1'b1; tick(2);
      page_btn = 1'b0; tick(3);
    end
    tick(16);

    // error overrides empty
    error_bit = 1'b1; empty_stack = 1'b1; value = $urandom(); stack_size = 10'd5;
    tick(16);

    // empty, then LED saturation boundaries
    error_bit = 1'b0; stack_size = 10'd0; tick(16);
    stack_size = 10'd300; empty_stack = 1'b0; tick(4);
    stack_size = 10'd126; tick(1);
    stack_size = 10'd127; tick(1);
    stack_size = 10'd128; tick(1);

    // reset mid-scan and mid-debounce
    reset = 1'b1; tick(1);
    reset = 1'b0; tick(8);
    page_btn = 1'b1; tick(4);
    reset = 1'b1; tick(1);
    reset = 1'b0; page_btn = 1'b0; tick(20);

    // button held through reset counts once stable afterwards
    page_btn = 1'b1; tick(10);
    reset = 1'b1; tick(2);
    reset = 1'b0; tick(10);
    page_btn = 1'b0; tick(10);

    // randomized traffic
    btn_left = 0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 19) == 0) value = $urandom();
      if ($urandom_range(0, 29) == 0) begin
        error_bit   = ($urandom_range(0, 3) == 0);
        empty_stack = ($urandom_range(0, 3) == 0);
        stack_size  = 10'($urandom_range(0, 1023));
      end
      if (btn_left == 0) begin
        page_btn = ~page_btn;
        btn_left = $urandom_range(1, 8);
      end
      btn_left--;
      reset = ($urandom_range(0, 249) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
